// File: rtl/q2_uart_tx_io.sv
// q2 bus I/O responder: decodes DATA/STATUS/DIV at BASE..BASE+2 and feeds a FIFO into an 8N1 UART.
// Define Q2_UART_PARITY_EN to insert an even-parity bit after the eight data bits.
module q2_uart_tx_io #(
  parameter logic [11:0] BASE       = 12'h800,
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter logic [11:0] DIV_RESET  = 12'd103
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] abus,
  inout  wire  [11:0] dbus,
  input  logic        rdm,
  input  logic        wrm,
  output logic        txd,
  output logic        irq
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef Q2_UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [11:0]           div_q;
  logic [11:0]           cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            sh_q, sh_d;
  logic                  par_q, par_d;
  logic                  txd_q, txd_d;
  logic                  ovf_q, wrm_q, rdm_q;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  hit, wr_ev, rd_fall, push, pop, full, empty, tick, busy;
  logic [1:0]            off;
  logic [11:0]           rd_val;
  logic [7:0]            head;

  assign hit     = (abus[11:2] == BASE[11:2]);
  assign off     = abus[1:0];
  assign wr_ev   = wrm & ~wrm_q;
  assign rd_fall = rdm_q & ~rdm;
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign push    = wr_ev & hit & (off == 2'd0) & ~full;
  assign head    = mem_q[rd_ptr_q];
  assign tick    = (cnt_q == '0);
  assign busy    = (state_q != ST_IDLE);
  assign irq     = empty & ~busy;
  assign txd     = txd_q;

  always_comb begin
    rd_val = '0;
    case (off)
      2'd1:    rd_val = {8'h00, ovf_q, busy, empty, ~full};
      2'd2:    rd_val = div_q;
      default: rd_val = '0;
    endcase
  end

  assign dbus = (rdm && hit && (off != 2'd3)) ? rd_val : 'z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrm_q <= 1'b0;
      rdm_q <= 1'b0;
      div_q <= DIV_RESET;
      ovf_q <= 1'b0;
    end else begin
      wrm_q <= wrm;
      rdm_q <= rdm;
      if (wr_ev && hit && (off == 2'd2)) div_q <= dbus;
      if (wr_ev && hit && (off == 2'd0) && full) ovf_q <= 1'b1;
      else if (rd_fall && hit && (off == 2'd1)) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dbus[7:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    pop     = 1'b0;
    if (state_q != ST_IDLE) cnt_d = tick ? div_q : cnt_q - 12'd1;
    case (state_q)
      ST_IDLE: if (!empty) begin
        pop     = 1'b1;
        sh_d    = head;
        par_d   = ^head;
        cnt_d   = div_q;
        state_d = ST_START;
      end
      ST_START: if (tick) begin
        bit_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA: if (tick) begin
        sh_d  = {1'b0, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
`ifdef Q2_UART_PARITY_EN
        if (bit_q == 3'd7) state_d = ST_PARITY;
`else
        if (bit_q == 3'd7) state_d = ST_STOP;
`endif
      end
`ifdef Q2_UART_PARITY_EN
      ST_PARITY: if (tick) state_d = ST_STOP;
`endif
      // Popping straight out of STOP keeps back-to-back frames gap-free.
      ST_STOP: if (tick) begin
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = head;
          par_d   = ^head;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // txd is registered from the current state, so the line lags the FSM by one clock
  // (enqueue at E, pop at E+1, start bit visible at E+2).
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = sh_q[0];
`ifdef Q2_UART_PARITY_EN
      ST_PARITY: txd_d = par_q;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end
endmodule

// File: tb/tb_q2_uart_tx_io.sv
// Bench for q2_uart_tx_io: bus tasks, a txd frame decoder, and scenario tasks with inline checks.
module tb_q2_uart_tx_io;
  localparam logic [11:0] BASE = 12'h800;
`ifdef Q2_UART_PARITY_EN
  localparam int unsigned FL = 11;
`else
  localparam int unsigned FL = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdm = 1'b0;
  logic        wrm = 1'b0;
  logic [11:0] abus = '0;
  logic        tb_oe = 1'b0;
  logic [11:0] tb_dout = '0;
  logic        txd, irq;
  wire  [11:0] dbus;

  assign dbus = tb_oe ? tb_dout : 'z;
  for (genvar g = 0; g < 12; g++) begin : g_pu
    pullup (dbus[g]);
  end

  q2_uart_tx_io #(.BASE(BASE), .DEPTH_LOG2(2), .DIV_RESET(12'd103)) dut (
    .clk(clk), .rst(rst), .abus(abus), .dbus(dbus),
    .rdm(rdm), .wrm(wrm), .txd(txd), .irq(irq));

  always #5 clk = ~clk;

  int unsigned checks = 0, failures = 0, cyc = 0, cur_div = 103;
  logic [7:0]  mon_data[$];
  int unsigned mon_start[$];
  int unsigned mon_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame decoder: every clock of every bit period must hold the same level.
  int unsigned m_per, m_st;
  logic [11:0] m_bits;
  logic        m_bad, m_abort;
  logic [7:0]  m_d;
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && txd === 1'b0) begin
        m_per = cur_div + 1; m_st = cyc; m_bits = '0; m_bits[0] = txd;
        m_bad = 1'b0; m_abort = 1'b0;
        for (int unsigned k = 1; k < FL * m_per; k++) begin
          @(negedge clk);
          if (rst === 1'b1) begin m_abort = 1'b1; break; end
          if (k % m_per == 0) m_bits[k / m_per] = txd;
          else if (txd !== m_bits[k / m_per]) m_bad = 1'b1;
        end
        if (!m_abort) begin
          m_d = m_bits[8:1];
          if (m_bits[FL-1] !== 1'b1) m_bad = 1'b1;
`ifdef Q2_UART_PARITY_EN
          if (m_bits[9] !== ^m_d) m_bad = 1'b1;
`endif
          mon_data.push_back(m_d);
          mon_start.push_back(m_st);
          if (m_bad) mon_err++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [1:0] off, input logic [11:0] val,
                           input int unsigned hold, output int unsigned e);
    @(negedge clk);
    abus = BASE + {10'd0, off}; tb_dout = val; tb_oe = 1'b1; wrm = 1'b1;
    @(posedge clk); #1 e = cyc;
    for (int unsigned i = 1; i < hold; i++) @(posedge clk);
    @(negedge clk);
    wrm = 1'b0; tb_oe = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [11:0] val);
    @(negedge clk);
    abus = BASE + {10'd0, off}; rdm = 1'b1;
    #2 val = dbus;
    @(negedge clk);
    rdm = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_mon();
    mon_data.delete(); mon_start.delete(); mon_err = 0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (mon_data.size() < n && t < budget) begin @(negedge clk); t++; end
    checks++;
    if (mon_data.size() < n) begin
      failures++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", mon_data.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [11:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; cur_div = 103;
    @(negedge clk);
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b expected 1", txd); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL reset_irq: got %b expected 1", irq); end
    checks++; if (dbus !== 12'hFFF) begin failures++; $display("FAIL reset_bus_idle: got %h expected fff", dbus); end
    bus_read(2'd1, v);
    checks++; if (v !== 12'h003) begin failures++; $display("FAIL reset_status: got %h expected 003", v); end
    bus_read(2'd3, v);
    checks++; if (v !== 12'hFFF) begin failures++; $display("FAIL reset_undecoded: got %h expected fff", v); end
    bus_read(2'd2, v);
    checks++; if (v !== 12'h067) begin failures++; $display("FAIL reset_div: got %h expected 067", v); end
    bus_read(2'd0, v);
    checks++; if (v !== 12'h000) begin failures++; $display("FAIL reset_data_read: got %h expected 000", v); end
  endtask

  task automatic test_single();
    logic [11:0] v;
    int unsigned e;
    bus_write(2'd2, 12'd1, 1, e); cur_div = 1;
    bus_read(2'd2, v);
    checks++; if (v !== 12'h001) begin failures++; $display("FAIL div_write: got %h expected 001", v); end
    clear_mon();
    bus_write(2'd0, 12'hF55, 1, e);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_fall: got %b expected 0", irq); end
    @(posedge clk); #1;
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL lat_e1: got %b expected 1", txd); end
    @(posedge clk); #1;
    checks++; if (txd !== 1'b0) begin failures++; $display("FAIL lat_e2: got %b expected 0", txd); end
    bus_read(2'd1, v);
    checks++; if (v !== 12'h007) begin failures++; $display("FAIL busy_status: got %h expected 007", v); end
    wait_frames(1, 100);
    if (mon_data.size() > 0) begin
      checks++; if (mon_data[0] !== 8'h55) begin failures++; $display("FAIL single_byte: got %h expected 55", mon_data[0]); end
      checks++; if (mon_start[0] !== e + 2) begin failures++; $display("FAIL single_start: got %0d expected %0d", mon_start[0], e + 2); end
    end
    checks++; if (mon_err !== 0) begin failures++; $display("FAIL single_framing: got %0d expected 0", mon_err); end
    repeat (4) @(negedge clk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise: got %b expected 1", irq); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] v;
    logic [7:0]  exp_q[$];
    int unsigned e, e1;
    bus_write(2'd2, 12'd0, 1, e); cur_div = 0;
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'($urandom));
      bus_write(2'd0, {4'($urandom), exp_q[i]}, 1, e);
      if (i == 0) e1 = e;
    end
    wait_frames(5, 5 * FL + 50);
    checks++; if (mon_data.size() != 5) begin failures++; $display("FAIL b2b_count: got %0d expected 5", mon_data.size()); end
    for (int i = 0; i < mon_data.size() && i < 5; i++) begin
      checks++; if (mon_data[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_byte%0d: got %h expected %h", i, mon_data[i], exp_q[i]); end
      checks++; if (mon_start[i] !== e1 + 2 + i * FL) begin failures++; $display("FAIL b2b_start%0d: got %0d expected %0d", i, mon_start[i], e1 + 2 + i * FL); end
    end
    checks++; if (mon_err !== 0) begin failures++; $display("FAIL b2b_framing: got %0d expected 0", mon_err); end
    bus_read(2'd1, v);
    checks++; if (v !== 12'h003) begin failures++; $display("FAIL b2b_status: got %h expected 003", v); end
  endtask

  task automatic test_random();
    logic [7:0]  exp_q[$];
    int unsigned e, e1, div, per;
    int n;
    for (int it = 0; it < 3; it++) begin
      div = $urandom_range(0, 3); n = $urandom_range(1, 4); per = div + 1;
      bus_write(2'd2, 12'(div), 1, e); cur_div = div;
      clear_mon(); exp_q.delete();
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(8'($urandom));
        bus_write(2'd0, {4'($urandom), exp_q[i]}, 1, e);
        if (i == 0) e1 = e;
      end
      wait_frames(n, n * FL * per + 50);
      for (int i = 0; i < mon_data.size() && i < n; i++) begin
        checks++; if (mon_data[i] !== exp_q[i]) begin failures++; $display("FAIL rnd%0d_byte%0d: got %h expected %h", it, i, mon_data[i], exp_q[i]); end
        checks++; if (mon_start[i] !== e1 + 2 + i * FL * per) begin failures++; $display("FAIL rnd%0d_start%0d: got %0d expected %0d", it, i, mon_start[i], e1 + 2 + i * FL * per); end
      end
      checks++; if (mon_err !== 0) begin failures++; $display("FAIL rnd%0d_framing: got %0d expected 0", it, mon_err); end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_overflow();
    logic [11:0] v;
    logic [7:0]  exp_q[$];
    int unsigned e;
    bus_write(2'd2, 12'd100, 1, e); cur_div = 100;
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(8'($urandom));
      bus_write(2'd0, {4'h0, exp_q[i]}, 1, e);
    end
    bus_read(2'd1, v);
    checks++; if (v !== 12'h00C) begin failures++; $display("FAIL ovf_set: got %h expected 00c", v); end
    bus_read(2'd1, v);
    checks++; if (v !== 12'h004) begin failures++; $display("FAIL ovf_clear: got %h expected 004", v); end
    wait_frames(5, 5 * FL * 101 + 100);
    repeat (FL * 101 + 20) @(negedge clk);
    checks++; if (mon_data.size() != 5) begin failures++; $display("FAIL ovf_count: got %0d expected 5", mon_data.size()); end
    for (int i = 0; i < mon_data.size() && i < 5; i++) begin
      checks++; if (mon_data[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_byte%0d: got %h expected %h", i, mon_data[i], exp_q[i]); end
    end
    checks++; if (mon_err !== 0) begin failures++; $display("FAIL ovf_framing: got %0d expected 0", mon_err); end
  endtask

  task automatic test_hold_wrm();
    logic [11:0] v;
    logic [7:0]  b;
    int unsigned e;
    bus_write(2'd2, 12'd0, 1, e); cur_div = 0;
    clear_mon();
    b = 8'($urandom);
    bus_write(2'd0, {4'h0, b}, 5, e);
    wait_frames(1, FL + 50);
    repeat (3 * FL) @(negedge clk);
    checks++; if (mon_data.size() != 1) begin failures++; $display("FAIL hold_count: got %0d expected 1", mon_data.size()); end
    if (mon_data.size() > 0) begin
      checks++; if (mon_data[0] !== b) begin failures++; $display("FAIL hold_byte: got %h expected %h", mon_data[0], b); end
    end
    bus_read(2'd1, v);
    checks++; if (v !== 12'h003) begin failures++; $display("FAIL hold_status: got %h expected 003", v); end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] v;
    int unsigned e;
    bus_write(2'd2, 12'd3, 1, e); cur_div = 3;
    clear_mon();
    bus_write(2'd0, 12'h000, 1, e);
    bus_write(2'd0, {4'h0, 8'($urandom)}, 1, e);
    repeat (6) @(negedge clk);
    checks++; if (txd !== 1'b0) begin failures++; $display("FAIL mid_pre_txd: got %b expected 0", txd); end
    #2 rst = 1'b1;
    #1;
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL mid_rst_txd: got %b expected 1", txd); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mid_rst_irq: got %b expected 1", irq); end
    repeat (2) @(negedge clk);
    rst = 1'b0; cur_div = 103;
    bus_read(2'd1, v);
    checks++; if (v !== 12'h003) begin failures++; $display("FAIL mid_status: got %h expected 003", v); end
    bus_read(2'd2, v);
    checks++; if (v !== 12'h067) begin failures++; $display("FAIL mid_div: got %h expected 067", v); end
    repeat (60) @(negedge clk);
    checks++; if (mon_data.size() != 0) begin failures++; $display("FAIL mid_discard: got %0d frames expected 0", mon_data.size()); end
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL mid_idle_txd: got %b expected 1", txd); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_overflow();
    test_hold_wrm();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/q2_uart_tx_io.md
# q2_uart_tx_io

Memory-mapped serial output responder for the q2 12-bit bus. It decodes a 4-word I/O window and answers the CPU's `rdm`/`wrm` strobes on the shared tri-state `dbus`. Bytes written to its data word go through a small FIFO and an 8N1 UART transmitter, with even parity as an optional extra. It sits beside the RAM on `abus`/`dbus` and gives the q2 a real output port in place of simulation-only display traps.

## Interface
- `BASE`, 12'h800: word address of the I/O window; must be 4-aligned.
- `DEPTH_LOG2`, 2: FIFO depth is 2**DEPTH_LOG2 entries of 8 bits.
- `DIV_RESET`, 12'd103: reset value of the baud divisor.
- `clk`  in  1  system clock, the same clock as the q2 core.
- `rst`  in  1  reset: asynchronous, active-high.
- `abus`  in  12  word address from the q2.
- `dbus`  inout  12  shared data bus; driven only while a read to a decoded register is in progress, `z` otherwise.
- `rdm`  in  1  read strobe from the q2; level-sensitive.
- `wrm`  in  1  write strobe from the q2; acted on at its rising edge.
- `txd`  out  1  serial output; idle high.
- `irq`  out  1  high while the FIFO is empty and the transmitter is idle.

## Operation
- Register map (offset from `BASE`):
  - +0 DATA: write enqueues `dbus[7:0]`; `dbus[11:8]` are ignored. Read returns 12'h000.
  - +1 STATUS (read-only): bit0 = not full, bit1 = FIFO empty, bit2 = tx busy, bit3 = overflow (sticky); bits 11:4 = 0.
  - +2 DIV: read/write, 12 bits; each serial bit lasts DIV+1 clocks.
  - +3: not decoded; `dbus` stays `z`; writes are ignored.
- Reads are combinational: `dbus` is driven whenever `rdm` is high and `abus` is BASE..BASE+2.
- Writes: `wrm_q` is `wrm` registered on `clk`. A write occurs on the `clk` edge where `wrm & ~wrm_q`; `abus`/`dbus` are sampled on that edge.
- DATA write with FIFO full: the byte is dropped and overflow is set. Full is evaluated before any pop on the same edge; there is no bypass.
- Overflow clears on the edge where `rdm_q & ~rdm` (falling edge of `rdm`) with `abus` = STATUS. Clear and set on the same edge: set wins.
- Transmitter FSM:
  - IDLE: if FIFO is non-empty, pop into the shift register and go to START.
  - START: `txd` = 0 for one bit period, then DATA.
  - DATA: 8 bits, LSB first, then PARITY if enabled, otherwise STOP.
  - STOP: `txd` = 1 for one bit period, then IDLE.
- Bit counter reloads from DIV at every bit boundary. A DIV write mid-frame takes effect at the next bit boundary.
- tx busy = state ≠ IDLE.

## Timing
- Reset values: `txd` = 1, `irq` = 1, `dbus` = `z`, FIFO empty, overflow = 0, DIV = DIV_RESET, FSM = IDLE, `wrm_q` = `rdm_q` = 0.
- Asserting `rst` mid-frame forces `txd` high immediately and discards FIFO contents.
- Latency: byte enqueued at edge E. IDLE pops at E+1. `txd` falls at E+2.
- Frame length: (10 or 11) × (DIV+1) clocks.
- Back-to-back: the next START follows STOP with no idle gap if the FIFO is non-empty.
- `irq` falls on the enqueue edge.
- FIFO pointers wrap modulo depth. Count ranges 0..2**DEPTH_LOG2.
- Holding `wrm` high for several clocks produces exactly one write.

## Configuration
- `Q2_UART_PARITY_EN` defined: the PARITY state is compiled in. It sends the even-parity bit (XOR of the 8 data bits) after bit 7. Frame = 11 bit periods.
- `Q2_UART_PARITY_EN` undefined: no PARITY state. Frame = 10 bit periods.
- The register map is identical in both builds.

## Test plan
- Reset, then read STATUS → `dbus` = 12'h003, `txd` = 1, `irq` = 1. Read +3 → `dbus` = `z`.
- DIV = 1, write DATA = 12'hF55 → `txd` falls 2 clocks after the write edge. Bits are 0,1,0,1,0,1,0,1,0, then 1, each 2 clocks; with parity a 0 is inserted before stop.
- DIV = 0, write 5 bytes back-to-back with depth 4:
  - the first pops immediately;
  - all 5 bytes are sent;
  - overflow stays 0;
  - frames are contiguous, no gap.
- DIV = 100, write 6 bytes quickly:
  - the 6th is dropped;
  - STATUS bit3 = 1 and bit0 = 0;
  - after the `rdm` falling edge, bit3 = 0.
- Hold `wrm` high 5 clocks on DATA → exactly one byte transmitted.
- Assert `rst` mid-DATA bit → `txd` = 1 immediately, STATUS = 12'h003, DIV = 103.
